// File: rtl/rs232_pkg.sv
// Shared register map, status bit positions and engine state encoding for the
// Avalon-MM RS-232 UART.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int OVR_BIT   = 3;
  localparam int FRM_BIT   = 2;
  localparam int DROP_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                              input logic ovr, input logic frm,
                                              input logic drop);
    logic [31:0] w;
    w            = 32'd0;
    w[RX_OK_BIT] = rx_ok;
    w[TX_OK_BIT] = tx_ok;
    w[OVR_BIT]   = ovr;
    w[FRM_BIT]   = frm;
    w[DROP_BIT]  = drop;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter: reloads to a full or half bit period and flags
// the last cycle of the period with tick; it parks at zero when not reloaded.
module uart_baud_cnt #(
  parameter int DIVISOR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int W = $clog2(DIVISOR);
  localparam logic [W-1:0] FULL = W'(DIVISOR - 1);
  localparam logic [W-1:0] HALF = W'(DIVISOR / 2 - 1);

  logic [W-1:0] cnt;

  // Full reload has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (load_full) begin
      cnt <= FULL;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (cnt != {W{1'b0}}) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == {W{1'b0}});

endmodule

// File: rtl/rs232_avm_uart.sv
// Avalon-MM slave UART (8N1): polled RX byte, TX byte and sticky status flags
// behind a fixed one-wait-state bus interface.
module rs232_avm_uart import rs232_pkg::*; #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int DIVISOR = CLK_HZ / BAUD;

  logic        req, first, commit;
  logic        rd0, rd8, wr4;
  logic [31:0] rd_mux;
  logic        rx_snap;

  logic        rx_ok, rx_overrun, frame_err, tx_drop;
  logic [7:0]  rx_byte;
  logic        rx_accept, rx_clear;

  logic        rx_meta, rx_sync;
  uart_state_t rx_state;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_hold, rx_tick, rx_load_half, rx_load_full, rx_good, rx_bad;

  uart_state_t tx_state;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_ok, tx_start, tx_tick, tx_load_full;

  logic        unused_wdata;
  assign unused_wdata = ^avs_writedata[31:8];

  // First request cycle stalls; the following cycle completes and commits.
  assign req    = avs_read | avs_write;
  assign first  = req & avs_waitrequest;
  assign commit = req & ~avs_waitrequest;
  assign rd0    = commit & avs_read & (avs_address == RX_BASE);
  assign rd8    = commit & avs_read & (avs_address == STATUS_BASE);
  assign wr4    = commit & avs_write & ~avs_read & (avs_address == TX_BASE);

  always_comb begin
    rd_mux = 32'd0;
    if (avs_read) begin
      case (avs_address)
        RX_BASE:     rd_mux = {24'd0, rx_byte};
        STATUS_BASE: rd_mux = status_word(rx_ok, tx_ok, rx_overrun, frame_err, tx_drop);
        default:     rd_mux = 32'd0;
      endcase
    end else begin
      rd_mux = 32'd0;
    end
  end

  // Read data is captured in the stall cycle; rx_snap remembers whether that
  // returned byte was fresh so only a reported byte is consumed.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      avs_waitrequest <= 1'b1;
      avs_readdata    <= 32'd0;
      rx_snap         <= 1'b0;
    end else begin
      avs_waitrequest <= ~first;
      if (first) begin
        avs_readdata <= rd_mux;
        rx_snap      <= avs_read & (avs_address == RX_BASE) & rx_ok;
      end
    end
  end

  // A same-cycle read-clear frees the holding register for the arriving byte.
  assign rx_clear  = rd0 & rx_snap;
  assign rx_accept = rx_good & (~rx_ok | rx_clear);

  // Status reads clear only the error bits they actually returned.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_ok      <= 1'b0;
      rx_byte    <= 8'd0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      rx_ok      <= rx_accept | (rx_ok & ~rx_clear);
      rx_overrun <= (rx_good & ~rx_accept) | (rx_overrun & ~(rd8 & avs_readdata[OVR_BIT]));
      frame_err  <= rx_bad | (frame_err & ~(rd8 & avs_readdata[FRM_BIT]));
      tx_drop    <= (wr4 & ~tx_ok) | (tx_drop & ~(rd8 & avs_readdata[DROP_BIT]));
      if (rx_accept) begin
        rx_byte <= rx_shift;
      end
    end
  end

  // Two-flop synchronizer; idles high like the line.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
    end
  end

  assign rx_load_half = (rx_state == IDLE) & ~rx_sync;
  assign rx_load_full = rx_tick & (((rx_state == START) & ~rx_sync) | (rx_state == DATA));
  assign rx_good      = (rx_state == STOP) & ~rx_hold & rx_tick & rx_sync;
  assign rx_bad       = (rx_state == STOP) & ~rx_hold & rx_tick & ~rx_sync;

  uart_baud_cnt #(.DIVISOR(DIVISOR)) u_rx_baud (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .load_half (rx_load_half),
    .load_full (rx_load_full),
    .tick      (rx_tick)
  );

  // RX sequencer; after a bad stop bit it parks in STOP until the line idles.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_state <= IDLE;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_hold  <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (~rx_sync) rx_state <= START;
        end
        START: begin
          if (rx_tick) begin
            if (~rx_sync) begin
              rx_state <= DATA;
              rx_bit   <= 3'd0;
            end else begin
              rx_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        STOP: begin
          if (rx_hold) begin
            if (rx_sync) begin
              rx_hold  <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (rx_tick) begin
            if (rx_sync) rx_state <= IDLE;
            else rx_hold <= 1'b1;
          end
        end
        default: begin
          rx_state <= IDLE;
          rx_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ok        = (tx_state == IDLE);
  assign tx_start     = wr4 & tx_ok;
  assign tx_load_full = tx_start | (tx_tick & (tx_state != IDLE));

  uart_baud_cnt #(.DIVISOR(DIVISOR)) u_tx_baud (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .load_half (1'b0),
    .load_full (tx_load_full),
    .tick      (tx_tick)
  );

  // TX sequencer; uart_txd is a flop so the line never glitches.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state <= IDLE;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_start) begin
            tx_shift <= avs_writedata[7:0];
            uart_txd <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_tick) begin
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= 3'd0;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_tick) begin
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= STOP;
            end else begin
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_tick) tx_state <= IDLE;
        end
        default: begin
          tx_state <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avm_uart.sv
// Randomized self-checking bench for rs232_avm_uart against a flag/byte-level
// model of the register map and serial framing.
`timescale 1ns/1ps
module tb_rs232_avm_uart;

  localparam int DIV = 434;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic        uart_rxd;
  logic        uart_txd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state.
  logic       m_rx_ok, m_tx_ok, m_ovr, m_frm, m_drop;
  logic [7:0] m_byte;

  rs232_avm_uart dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_readdata    (avs_readdata),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_waitrequest (avs_waitrequest),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd)
  );

  always #10 avm_clk = ~avm_clk;
  always @(posedge avm_clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] m_status();
    logic [31:0] w;
    w = {24'd0, m_rx_ok, m_tx_ok, 2'b00, m_ovr, m_frm, m_drop, 1'b0};
    m_ovr = 1'b0; m_frm = 1'b0; m_drop = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] m_read_rx();
    m_rx_ok = 1'b0;
    return {24'd0, m_byte};
  endfunction

  function automatic void m_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_frm = 1'b1;
    else if (m_rx_ok) m_ovr = 1'b1;
    else begin m_byte = b; m_rx_ok = 1'b1; end
  endfunction

  function automatic void m_reset();
    m_rx_ok = 1'b0; m_tx_ok = 1'b1; m_ovr = 1'b0; m_frm = 1'b0; m_drop = 1'b0;
  endfunction

  task automatic bus(input bit r, input bit w, input logic [4:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n;
    @(negedge avm_clk);
    avs_address = a; avs_read = r; avs_write = w; avs_writedata = wd;
    n = 0;
    while (avs_waitrequest && n < 8) begin
      @(negedge avm_clk);
      n++;
    end
    checks++;
    if (n != 1) begin
      $display("FAIL bus_latency addr=%0d: waited %0d cycles, required 1", a, n);
      errors++;
    end
    rd = avs_readdata;
    @(posedge avm_clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge avm_clk); #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge avm_clk);
      uart_rxd = f[i];
      repeat (DIV - 1) @(negedge avm_clk);
    end
    @(negedge avm_clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge avm_clk);
    m_frame(b, stop);
  endtask

  task automatic test_reset();
    logic [3:0] wr_seen;
    logic [31:0] d0, d1;
    avm_rst = 1'b1; uart_rxd = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 5'd0; avs_writedata = 32'd0;
    m_reset(); m_byte = 8'd0;
    repeat (3) @(negedge avm_clk);
    checks++;
    if (avs_readdata !== 32'd0 || avs_waitrequest !== 1'b1 || uart_txd !== 1'b1) begin
      $display("FAIL reset_values: readdata=%h wait=%b txd=%b, required 0/1/1",
               avs_readdata, avs_waitrequest, uart_txd);
      errors++;
    end
    avm_rst = 1'b0;
    repeat (2) @(negedge avm_clk);
    // Held status read: waitrequest must toggle 1,0,1,0.
    avs_address = 5'd8; avs_read = 1'b1;
    wr_seen[0] = avs_waitrequest;
    @(negedge avm_clk); wr_seen[1] = avs_waitrequest; d0 = avs_readdata;
    @(negedge avm_clk); wr_seen[2] = avs_waitrequest;
    @(negedge avm_clk); wr_seen[3] = avs_waitrequest; d1 = avs_readdata;
    @(posedge avm_clk); #1; avs_read = 1'b0;
    checks++;
    if (wr_seen !== 4'b0101) begin
      $display("FAIL held_wait: pattern %b (cycle0 in lsb), required 0101", wr_seen);
      errors++;
    end
    checks++;
    if (d0 !== 32'h40 || d1 !== 32'h40) begin
      $display("FAIL reset_status: got %h/%h, required 00000040", d0, d1);
      errors++;
    end
  endtask

  task automatic test_decode();
    logic [31:0] d, exp;
    bus(1'b0, 1'b1, 5'd0, 32'h000000AB, d);
    bus(1'b0, 1'b1, 5'd8, 32'h000000FF, d);
    bus(1'b1, 1'b1, 5'd4, 32'h00000077, d);
    checks++;
    if (d !== 32'd0) begin
      $display("FAIL read_wins: readdata %h, required 00000000", d);
      errors++;
    end
    bus(1'b1, 1'b0, 5'd12, 32'd0, d);
    checks++;
    if (d !== 32'd0) begin
      $display("FAIL bad_addr: readdata %h, required 00000000", d);
      errors++;
    end
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp || uart_txd !== 1'b1) begin
      $display("FAIL decode_status: got %h txd=%b, required %h txd=1", d, uart_txd, exp);
      errors++;
    end
  endtask

  task automatic test_rx_byte(input logic [7:0] b);
    logic [31:0] d, exp;
    send_rx(b, 1'b1);
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL rx_status: got %h, required %h", d, exp); errors++; end
    bus(1'b1, 1'b0, 5'd0, 32'd0, d); exp = m_read_rx();
    checks++;
    if (d !== exp) begin $display("FAIL rx_data: got %h, required %h", d, exp); errors++; end
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL rx_cleared: got %h, required %h", d, exp); errors++; end
    bus(1'b1, 1'b0, 5'd0, 32'd0, d); exp = m_read_rx();
    checks++;
    if (d !== exp) begin $display("FAIL rx_stale: got %h, required %h", d, exp); errors++; end
  endtask

  task automatic test_overrun();
    logic [31:0] d, exp;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
      checks++;
      if (d !== exp) begin $display("FAIL ovr_status%0d: got %h, required %h", i, d, exp); errors++; end
    end
    bus(1'b1, 1'b0, 5'd0, 32'd0, d); exp = m_read_rx();
    checks++;
    if (d !== exp) begin $display("FAIL ovr_data: got %h, required %h", d, exp); errors++; end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, exp;
    send_rx(8'h55, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
      checks++;
      if (d !== exp) begin $display("FAIL frm_status%0d: got %h, required %h", i, d, exp); errors++; end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d, exp;
    @(negedge avm_clk); uart_rxd = 1'b0;
    repeat (100) @(negedge avm_clk);
    uart_rxd = 1'b1;
    repeat (800) @(negedge avm_clk);
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL glitch_status: got %h, required %h", d, exp); errors++; end
  endtask

  task automatic test_tx_frame(input logic [7:0] b, input bit with_drop);
    logic [31:0] d, exp;
    logic [9:0]  f;
    int c0;
    f = {1'b1, b, 1'b0};
    bus(1'b0, 1'b1, 5'd4, {24'hFFFFFF, b}, d);
    c0 = cyc; m_tx_ok = 1'b0;
    if (with_drop) begin
      bus(1'b0, 1'b1, 5'd4, {24'd0, ~b}, d); m_drop = 1'b1;
      for (int i = 0; i < 2; i++) begin
        bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
        checks++;
        if (d !== exp) begin $display("FAIL drop_status%0d: got %h, required %h", i, d, exp); errors++; end
      end
    end
    for (int i = 0; i < 10; i++) begin
      wait_until(c0 + DIV / 2 + DIV * i);
      checks++;
      if (uart_txd !== f[i]) begin
        $display("FAIL tx_bit%0d byte=%h: txd %b, required %b", i, b, uart_txd, f[i]);
        errors++;
      end
    end
    wait_until(c0 + 10 * DIV - 1);
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL tx_busy_end: got %h, required %h", d, exp); errors++; end
    m_tx_ok = 1'b1;
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL tx_ok_back: got %h, required %h", d, exp); errors++; end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d, exp;
    int c0;
    bus(1'b0, 1'b1, 5'd4, 32'h00000000, d);
    c0 = cyc; m_tx_ok = 1'b0;
    wait_until(c0 + 1000);
    checks++;
    if (uart_txd !== 1'b0) begin $display("FAIL mid_tx_line: txd %b, required 0", uart_txd); errors++; end
    @(negedge avm_clk); avm_rst = 1'b1;
    #2;
    checks++;
    if (uart_txd !== 1'b1) begin $display("FAIL async_txd: txd %b, required 1", uart_txd); errors++; end
    repeat (3) @(negedge avm_clk);
    avm_rst = 1'b0;
    m_reset();
    bus(1'b1, 1'b0, 5'd8, 32'd0, d); exp = m_status();
    checks++;
    if (d !== exp) begin $display("FAIL post_reset_status: got %h, required %h", d, exp); errors++; end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_rx_byte(8'hA5);
    for (int k = 0; k < 2; k++) test_rx_byte(8'($urandom_range(0, 255)));
    test_overrun();
    test_frame_err();
    test_glitch();
    test_rx_byte(8'($urandom_range(0, 255)));
    test_tx_frame(8'h3C, 1'b0);
    test_tx_frame(8'($urandom_range(0, 255)), 1'b0);
    test_tx_frame(8'($urandom_range(0, 255)), 1'b1);
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
